// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII receive framer: preamble/SFD strip, FCS and length check
// Optional GMII_RX_FRAMER_STRIP_FCS_EN: hold back five bytes so the FCS is never emitted.
module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic       rx_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  input  logic       rx_er,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_err,
  output logic       stat_good,
  output logic       stat_bad
);

`ifdef GMII_RX_FRAMER_STRIP_FCS_EN
  localparam int P = 5;
`else
  localparam int P = 1;
`endif
  localparam logic [2:0]  P_FULL      = 3'(P);
  localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L       = 16'(MAX_LEN);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        first_q, first_d;
  logic [7:0]  buf_q [P];
  logic [7:0]  buf_d [P];
  logic [2:0]  fill_q, fill_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic        ferr_q, ferr_d, good_q, good_d, bad_q, bad_d;
  logic        frame_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    first_d   = first_q;
    buf_d     = buf_q;
    fill_d    = fill_q;
    data_d    = 8'h00;
    valid_d   = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    ferr_d    = 1'b0;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    frame_bad = err_q | (crc_q != CRC_RESIDUE) | (cnt_q < MIN_L) | (cnt_q > MAX_L);
    unique case (state_q)
      S_IDLE: if (rx_dv) state_d = (rx_data == 8'h55) ? S_PRE : S_DROP;
      S_PRE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rx_data == 8'hD5) begin
          state_d = S_DATA;
          crc_d   = CRC_INIT;
          cnt_d   = 16'd0;
          err_d   = 1'b0;
          first_d = 1'b1;
          fill_d  = 3'd0;
        end else if (rx_data != 8'h55) begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (rx_dv) begin
          crc_d = crc_byte(crc_q, rx_data);
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (rx_er) err_d = 1'b1;
          // A full buffer shifts: the oldest byte leaves, the new one enters at the tail.
          if (fill_q == P_FULL) begin
            valid_d = 1'b1;
            data_d  = buf_q[0];
            sof_d   = first_q;
            first_d = 1'b0;
            for (int i = 0; i < P - 1; i++) buf_d[i] = buf_q[i + 1];
            buf_d[P-1] = rx_data;
          end else begin
            for (int i = 0; i < P; i++) if (fill_q == 3'(i)) buf_d[i] = rx_data;
            fill_d = fill_q + 3'd1;
          end
        end else begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          eof_d   = 1'b1;
          fill_d  = 3'd0;
          first_d = 1'b0;
          if (fill_q == P_FULL) begin
            data_d = buf_q[0];
            sof_d  = first_q;
            ferr_d = frame_bad;
            good_d = !frame_bad;
            bad_d  = frame_bad;
          end else begin
            sof_d  = 1'b1;
            ferr_d = 1'b1;
            bad_d  = 1'b1;
          end
        end
      end
      S_DROP: if (!rx_dv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      for (int i = 0; i < P; i++) buf_q[i] <= 8'h00;
      fill_q  <= 3'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ferr_q  <= 1'b0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ferr_q  <= ferr_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign out_err   = ferr_q;
  assign stat_good = good_q;
  assign stat_bad  = bad_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb/tb_gmii_rx_framer.sv - directed bench for gmii_rx_framer
module tb_gmii_rx_framer;

  typedef struct packed {logic [7:0] d; logic dv; logic er; logic rst;} beat_t;
  typedef struct packed {logic [7:0] d; logic sof; logic eof; logic err; logic good; logic bad;} obeat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_dv = 1'b0;
  logic       rx_er = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_sof, out_eof, out_err, stat_good, stat_bad;

  beat_t      stim[$];
  obeat_t     out_q[$];
  obeat_t     exp_q[$];
  logic [7:0] frm[$];
  int         checks = 0;
  int         errors = 0;
  int         stray = 0;

  gmii_rx_framer dut (
    .rx_clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_err(out_err), .stat_good(stat_good), .stat_bad(stat_bad)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) out_q.push_back('{out_data, out_sof, out_eof, out_err, stat_good, stat_bad});
      else if (out_sof | out_eof | out_err | stat_good | stat_bad) stray++;
      if (out_valid && !out_eof && (out_err | stat_good | stat_bad)) stray++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_payload(input int n, input int seed);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'(i * 13 + seed * 7 + 3));
  endtask

  task automatic add_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[k]) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ frm[k][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic push_idle(input int n, input logic er);
    for (int i = 0; i < n; i++) stim.push_back('{8'h00, 1'b0, er, 1'b0});
  endtask

  task automatic push_frame(input int er_idx);
    for (int i = 0; i < 7; i++) stim.push_back('{8'h55, 1'b1, 1'b0, 1'b0});
    stim.push_back('{8'hD5, 1'b1, 1'b0, 1'b0});
    foreach (frm[i]) stim.push_back('{frm[i], 1'b1, (i == er_idx), 1'b0});
  endtask

  task automatic expect_frame(input logic bad);
    int nb;
`ifdef GMII_RX_FRAMER_STRIP_FCS_EN
    nb = frm.size() - 4;
`else
    nb = frm.size();
`endif
    if (nb < 1) exp_q.push_back('{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
    else
      for (int i = 0; i < nb; i++)
        exp_q.push_back('{frm[i], (i == 0), (i == nb - 1), (i == nb - 1) & bad,
                          (i == nb - 1) & !bad, (i == nb - 1) & bad});
  endtask

  task automatic run();
    foreach (stim[k]) begin
      @(posedge clk); #1;
      rst_n   = !stim[k].rst;
      rx_data = stim[k].d;
      rx_dv   = stim[k].dv;
      rx_er   = stim[k].er;
      if (stim[k].rst) out_q.delete();
    end
    stim.delete();
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic compare(input string tag);
    int mism;
    int n;
    mism = 0;
    chk({tag, "_beats"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (out_q[i] !== exp_q[i]) begin
        mism++;
        if (mism <= 3) $display("  %s beat %0d got %h exp %h", tag, i, out_q[i], exp_q[i]);
      end
    chk({tag, "_content"}, mism, 0);
    chk({tag, "_stray"}, stray, 0);
    out_q.delete();
    exp_q.delete();
    stray = 0;
  endtask

  initial begin
    #10;
    chk("rst_outputs", {24'h0, out_data} | {25'h0, out_valid, out_sof, out_eof, out_err, stat_good, stat_bad}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    gen_payload(60, 1); add_fcs();
    push_idle(2, 1'b0); push_frame(-1); push_idle(2, 1'b0); expect_frame(1'b0);
    run(); compare("good64");

    gen_payload(60, 2); add_fcs(); frm[10] = frm[10] ^ 8'h01;
    push_frame(-1); push_idle(2, 1'b0); expect_frame(1'b1);
    run(); compare("bitflip");

    gen_payload(60, 3); add_fcs();
    push_frame(30); push_idle(2, 1'b0); expect_frame(1'b1);
    run(); compare("rx_er_data");

    gen_payload(60, 4); add_fcs();
    push_idle(3, 1'b1); push_frame(-1); push_idle(3, 1'b1); expect_frame(1'b0);
    run(); compare("rx_er_ifg");

    gen_payload(16, 5); add_fcs();
    push_frame(-1); push_idle(2, 1'b0); expect_frame(1'b1);
    run(); compare("runt20");

    gen_payload(1596, 6); add_fcs();
    push_frame(-1); push_idle(2, 1'b0); expect_frame(1'b1);
    run(); compare("giant1600");

    frm.delete();
    push_frame(-1); push_idle(2, 1'b0); expect_frame(1'b1);
    run(); compare("empty");

    stim.push_back('{8'h55, 1'b1, 1'b0, 1'b0});
    stim.push_back('{8'h55, 1'b1, 1'b0, 1'b0});
    stim.push_back('{8'h5A, 1'b1, 1'b0, 1'b0});
    stim.push_back('{8'hD5, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 20; i++) stim.push_back('{8'(i + 8'h20), 1'b1, 1'b0, 1'b0});
    push_idle(2, 1'b0);
    run(); compare("badpre");

    gen_payload(60, 7); add_fcs();
    push_frame(-1); push_idle(1, 1'b0); expect_frame(1'b0);
    gen_payload(60, 8); add_fcs();
    push_frame(-1); push_idle(2, 1'b0); expect_frame(1'b0);
    run(); compare("b2b");

    gen_payload(60, 9); add_fcs();
    for (int i = 0; i < 7; i++) stim.push_back('{8'h55, 1'b1, 1'b0, 1'b0});
    stim.push_back('{8'hD5, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 40; i++) stim.push_back('{frm[i], 1'b1, 1'b0, 1'b0});
    for (int i = 40; i < 43; i++) stim.push_back('{frm[i], 1'b1, 1'b0, 1'b1});
    for (int i = 43; i < 64; i++) stim.push_back('{8'h11, 1'b1, 1'b0, 1'b0});
    push_idle(3, 1'b0);
    gen_payload(60, 10); add_fcs();
    push_frame(-1); push_idle(2, 1'b0); expect_frame(1'b0);
    run(); compare("midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmii_rx_framer.md
Name: gmii_rx_framer

Overview:
- Receive-side frame delineator. Sits directly downstream of the RGMII DDR input stage and consumes its GMII byte stream (rx_data/rx_dv/rx_er) in the rx_clk domain.
- Strips preamble and SFD, checks Ethernet FCS (CRC-32), and checks frame length.
- Emits a byte stream with start/end-of-frame markers and a per-frame error flag for the MAC receive FIFO.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes after SFD, FCS included.
- MAX_LEN, 1518, maximum legal frame length in bytes after SFD, FCS included.

Ports:
- rx_clk  in  1  GMII receive clock (125 MHz); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  GMII receive byte.
- rx_dv  in  1  GMII data valid.
- rx_er  in  1  GMII receive error.
- out_data  out  8  frame byte.
- out_valid  out  1  out_data valid this cycle; no backpressure.
- out_sof  out  1  first beat of frame; qualified by out_valid.
- out_eof  out  1  last beat of frame; qualified by out_valid.
- out_err  out  1  frame bad; meaningful only on the eof beat, 0 otherwise.
- stat_good  out  1  one-cycle pulse with a good eof beat.
- stat_bad  out  1  one-cycle pulse with a bad eof beat.

Behaviour:
- Reset: state IDLE; buffer empty; CRC = 0xFFFFFFFF; length count 0. All outputs 0, asynchronously on rst_n low.
- All outputs are registered.
- State machine (inputs sampled each rx_clk):
  - IDLE: rx_dv=1 and rx_data=0x55 -> PRE. rx_dv=1 with any other byte -> DROP.
  - PRE: rx_dv=1 and 0x55 -> stay. 0xD5 -> DATA, with CRC := 0xFFFFFFFF and count := 0. Any other byte -> DROP. rx_dv=0 -> IDLE, no output.
  - DATA: each rx_dv=1 byte updates the CRC and is pushed into the hold buffer; count increments and saturates at 0xFFFF. rx_dv=0 -> IDLE and end-of-frame is processed.
  - DROP: wait for rx_dv=0 -> IDLE. Nothing is emitted.
- CRC: reflected polynomial 0xEDB88320, LSB-first, 8 bits per cycle, computed over all bytes after SFD including FCS. The FCS is good when the final register equals residue 0xDEBB20E3.
- Error sticky bit: cleared on SFD. Set by rx_er=1 while rx_dv=1 in DATA. rx_er while rx_dv=0 (carrier extension / false carrier) is ignored in every state.
- Frame error = sticky error OR CRC residue mismatch OR count < MIN_LEN OR count > MAX_LEN.
- Hold buffer depth P: P=1 normally; P=5 under STRIP_FCS_EN.
  - A byte arriving while the buffer holds P bytes causes the oldest byte to be emitted on the next cycle.
  - out_sof is set on the first emitted beat of the frame.
- End-of-frame (first rx_dv=0 cycle in DATA):
  - On the next cycle, the oldest buffered byte is emitted with out_eof=1, out_err and stat_good/stat_bad set. Remaining buffered bytes are discarded and the buffer is cleared.
  - If the buffer holds no byte eligible for output, a single beat is emitted instead: out_data=0x00, out_sof=1, out_eof=1, out_err=1, stat_bad=1. This covers a zero-byte frame, and under STRIP_FCS_EN any frame of 4 bytes or fewer.
- Frames longer than MAX_LEN are passed through in full and flagged at eof; there is no truncation.
- Back-to-back frames: the eof flush happens in the cycle after rx_dv falls, in parallel with IDLE/PRE of the next frame. A one-cycle gap is legal and causes no beat loss.
- Reset mid-frame: the buffer is discarded with no eof beat. If rx_dv is still high after release, the first sampled byte is not 0x55 in general, so the FSM goes to DROP until rx_dv=0.
- Latency: with P=1, a byte is emitted 1 cycle after the following byte is sampled, or 1 cycle after rx_dv falls.

Optional Feature:
- Macro: GMII_RX_FRAMER_STRIP_FCS_EN.
- Defined: P=5. The four FCS bytes are never emitted, and the eof beat carries the last data byte. Length and CRC checks still include the FCS.
- Undefined: P=1. All bytes after SFD, including the 4 FCS bytes, are emitted, and the eof beat carries the last FCS byte.

Test Plan:
- 7x0x55, 0xD5, 60 payload bytes + correct FCS, then rx_dv low -> 64 beats (60 with strip). out_sof on beat 1, out_eof on the last beat, out_err=0, one stat_good pulse.
- Same frame with one payload bit flipped -> same beat count, out_err=1 and stat_bad=1 on eof only.
- Good 64-byte frame with rx_er=1 for one cycle at byte 30 -> out_err=1 at eof. Same frame with rx_er=1 only during the IFG (rx_dv=0) -> out_err=0.
- 20-byte frame with correct FCS -> out_err=1 (runt). 1600-byte frame -> all bytes emitted, out_err=1. SFD then immediate rx_dv low -> single beat, data 0x00, sof=eof=err=1.
- Preamble 0x55,0x55,0x5A,0xD5,... -> zero output beats, FSM returns to IDLE when rx_dv falls. Two good frames separated by 1 idle cycle -> two complete frames, both good.
- rst_n asserted at byte 40 of a frame, released while rx_dv is still high -> no eof beat, no output until the next well-formed frame, which is received good.
